fetch_unit: RTL

Instruction-fetch stage that owns the program counter and supplies the decode/branch path with (pc, instr) pairs.
- Issues one instruction-memory request at a time and holds the returned word in a single-entry IF/ID buffer.
- Consumes the redirect produced by the branch unit (taken branches) and by jal/jalr resolution.
- Discards any in-flight fetch on a redirect and raises a fault on misaligned targets.

---
 rtl/fetch_pkg.sv | 19 +
 rtl/fetch_buf.sv | 35 +++
 rtl/fetch_unit.sv | 100 ++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared fetch-stage types: FSM states, NOP encoding, default reset pc,
// plus the branch funct3 encodings used by the branch unit.
package fetch_pkg;

    typedef enum logic [2:0] {
        F3_BEQ  = 3'b000,
        F3_BNE  = 3'b001,
        F3_BLT  = 3'b100,
        F3_BGE  = 3'b101,
        F3_BLTU = 3'b110,
        F3_BGEU = 3'b111
    } f3_br_t;

    typedef enum logic [1:0] {FETCH, WAIT, DROP, FAULT} fetch_state_t;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/fetch_buf.sv
// Single-entry IF/ID buffer: flush beats refill, refill beats consume.
module fetch_buf
    import fetch_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            fill,
    input  logic [XLEN-1:0] fill_pc,
    input  logic [31:0]     fill_instr,
    input  logic            id_ready,
    output logic            valid,
    output logic [XLEN-1:0] pc,
    output logic [31:0]     instr
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            pc    <= '0;
            instr <= NOP_INSTR;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (fill) begin
            valid <= 1'b1;
            pc    <= fill_pc;
            instr <= fill_instr;
        end else if (valid && id_ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the pc, keeps one imem request in flight and
// feeds the IF/ID buffer; redirects flush the buffer and drop stale words.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    output logic            imem_resp_ready,
    input  logic [31:0]     imem_resp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            if_valid,
    output logic [XLEN-1:0] if_pc,
    output logic [31:0]     if_instr,
    input  logic            id_ready,
    output logic            misalign_exc,
    output logic [XLEN-1:0] misalign_pc
);

    fetch_state_t    state;
    logic [XLEN-1:0] pc;
    logic            drop_to_fault;

    logic buf_free, req_hs, resp_hs, redir_ok, redir_bad, outstanding_after, fill;

    assign buf_free        = !if_valid || id_ready;
    assign imem_req_valid  = rst_n && (state == FETCH) && buf_free;
    assign imem_req_addr   = pc;
    assign imem_resp_ready = ((state == WAIT) && buf_free) || (state == DROP);

    assign req_hs    = imem_req_valid && imem_req_ready;
    assign resp_hs   = imem_resp_valid && imem_resp_ready;
    assign redir_ok  = redirect_valid && (redirect_pc[1:0] == 2'b00);
    assign redir_bad = redirect_valid && (redirect_pc[1:0] != 2'b00);

    // A request still owed a response after this edge must be drained in DROP.
    assign outstanding_after = ((state == FETCH) && req_hs) ||
                               (((state == WAIT) || (state == DROP)) && !resp_hs);

    assign fill = (state == WAIT) && resp_hs && !redirect_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= FETCH;
            pc            <= RESET_PC;
            drop_to_fault <= 1'b0;
            misalign_exc  <= 1'b0;
            misalign_pc   <= '0;
        end else begin
            misalign_exc <= redir_bad;
            if (redir_bad) begin
                misalign_pc   <= redirect_pc;
                state         <= outstanding_after ? DROP : FAULT;
                drop_to_fault <= outstanding_after;
            end else if (redir_ok) begin
                pc            <= redirect_pc;
                state         <= outstanding_after ? DROP : FETCH;
                drop_to_fault <= 1'b0;
            end else begin
                case (state)
                    FETCH: if (req_hs) state <= WAIT;
                    WAIT: begin
                        if (resp_hs) begin
                            pc    <= pc + XLEN'(4);
                            state <= FETCH;
                        end
                    end
                    DROP: begin
                        if (imem_resp_valid) begin
                            state         <= drop_to_fault ? FAULT : FETCH;
                            drop_to_fault <= 1'b0;
                        end
                    end
                    default: state <= state;  // FAULT waits for an aligned redirect
                endcase
            end
        end
    end

    fetch_buf #(.XLEN(XLEN)) u_buf (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (redirect_valid),
        .fill       (fill),
        .fill_pc    (pc),
        .fill_instr (imem_resp_data),
        .id_ready   (id_ready),
        .valid      (if_valid),
        .pc         (if_pc),
        .instr      (if_instr)
    );

endmodule
